// File: rtl/proj_mux_pkg.sv
// ---------------------------------------------------------------------------
// proj_mux_pkg
// Shared definitions for the multi-project pad multiplexer.
//   - FSM state encoding for the switch sequencer (IDLE / OFF / ON)
//   - safe_oeb(): the all-ones oeb pattern used whenever the pads are parked
//   - slice_base(): base bit of project k inside a flattened IO bus
// No ports (package).
// ---------------------------------------------------------------------------
package proj_mux_pkg;

    // Switch sequencer states, kept as plain constants so the encoding stays
    // stable across tools and netlists that still reference the raw values.
    typedef logic [1:0] mux_state_t;
    localparam mux_state_t IDLE = 2'd0;
    localparam mux_state_t OFF  = 2'd1;
    localparam mux_state_t ON   = 2'd2;

    // Widest pad bus the helpers below are able to describe.
    localparam int MAX_IO_W = 128;

    // All-ones oeb pattern of width io_w (1 = pad hi-Z); callers cast the
    // result down to their own pad width.
    function automatic logic [MAX_IO_W-1:0] safe_oeb(input int io_w);
        logic [MAX_IO_W-1:0] v;
        v = '0;
        for (int i = 0; i < MAX_IO_W; i++) begin
            if (i < io_w) v[i] = 1'b1;
        end
        return v;
    endfunction

    // First bit of project k's slice inside a flattened bus.
    function automatic int slice_base(input int k, input int io_w);
        return k * io_w;
    endfunction

endpackage

// File: rtl/proj_pad_mux.sv
// ---------------------------------------------------------------------------
// proj_pad_mux
// Registered N-to-1 slice multiplexer for the shared IO pads. When out_en is
// low (or sel names no project) the pads are driven to the safe value:
// io_out = 0, io_oeb = all ones.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   out_en        pads may follow the selected project
//   sel           index of the project driving the pads
//   proj_io_out   flattened io_out of all projects, slice k = [k*IO_W +: IO_W]
//   proj_io_oeb   flattened io_oeb of all projects
//   io_out        registered pad output
//   io_oeb        registered pad output enable (1 = hi-Z)
// ---------------------------------------------------------------------------
module proj_pad_mux
    import proj_mux_pkg::*;
#(
    parameter int N_PROJ = 8,
    parameter int SEL_W  = 4,
    parameter int IO_W   = 38
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   out_en,
    input  logic [SEL_W-1:0]       sel,
    input  logic [N_PROJ*IO_W-1:0] proj_io_out,
    input  logic [N_PROJ*IO_W-1:0] proj_io_oeb,
    output logic [IO_W-1:0]        io_out,
    output logic [IO_W-1:0]        io_oeb
);

    localparam logic [IO_W-1:0] SAFE_OEB = IO_W'(safe_oeb(IO_W));

    logic [IO_W-1:0] mux_out;
    logic [IO_W-1:0] mux_oeb;

    // Compare-and-select over every project rather than a computed part
    // select, so an out-of-range sel can never address past the bus.
    always_comb begin
        mux_out = '0;
        mux_oeb = SAFE_OEB;
        for (int k = 0; k < N_PROJ; k++) begin
            if (sel == SEL_W'(k)) begin
                mux_out = proj_io_out[slice_base(k, IO_W) +: IO_W];
                mux_oeb = proj_io_oeb[slice_base(k, IO_W) +: IO_W];
            end
        end
    end

    // One cycle of latency from project outputs to pads; parked pads are safe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            io_out <= '0;
            io_oeb <= SAFE_OEB;
        end else if (out_en) begin
            io_out <= mux_out;
            io_oeb <= mux_oeb;
        end else begin
            io_out <= '0;
            io_oeb <= SAFE_OEB;
        end
    end

endmodule

// File: rtl/proj_mux_ctrl.sv
// ---------------------------------------------------------------------------
// proj_mux_ctrl
// Owns N_PROJ wrapped projects and connects at most one of them to the shared
// IO pads. A select request (valid/ready) triggers a sequenced switch: all
// projects are deactivated, the pads sit hi-Z for GUARD_CYCLES, then the new
// project is enabled. Selections >= N_PROJ deselect everything.
// Optional build macro: SWITCH_CNT_EN adds a saturating 16-bit count of
// completed project activations on port switch_cnt.
// Ports:
//   wb_clk_i, wb_rst_i   clock, asynchronous active-high reset
//   req_valid, req_sel   select request; req_sel >= N_PROJ means "none"
//   req_ready            request can be accepted (sequencer idle)
//   busy                 switch sequence in progress
//   cur_valid, cur_sel   currently active project (cur_sel = 0 when none)
//   active_o             one-hot (or zero) enable to each project wrapper
//   proj_io_out/oeb      flattened project pad outputs, slice k = [k*IO_W +: IO_W]
//   io_out, io_oeb       registered pad outputs
//   switch_cnt           (SWITCH_CNT_EN only) completed activations, saturating
// ---------------------------------------------------------------------------
module proj_mux_ctrl
    import proj_mux_pkg::*;
#(
    parameter int N_PROJ       = 8,
    parameter int SEL_W        = 4,
    parameter int IO_W         = 38,
    parameter int GUARD_CYCLES = 4
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    input  logic                   req_valid,
    input  logic [SEL_W-1:0]       req_sel,
    output logic                   req_ready,
    output logic                   busy,
    output logic                   cur_valid,
    output logic [SEL_W-1:0]       cur_sel,
    output logic [N_PROJ-1:0]      active_o,
    input  logic [N_PROJ*IO_W-1:0] proj_io_out,
    input  logic [N_PROJ*IO_W-1:0] proj_io_oeb,
    output logic [IO_W-1:0]        io_out,
    output logic [IO_W-1:0]        io_oeb
`ifdef SWITCH_CNT_EN
    ,
    output logic [15:0]            switch_cnt
`endif
);

    localparam int                CNT_W      = $clog2(GUARD_CYCLES) + 1;
    localparam logic [CNT_W-1:0]  GUARD_LOAD = CNT_W'(GUARD_CYCLES - 1);
    localparam logic [SEL_W-1:0]  SEL_LIMIT  = SEL_W'(N_PROJ);
    localparam logic [N_PROJ-1:0] ONE_HOT_0  = N_PROJ'(1);

    mux_state_t       state;
    logic [CNT_W-1:0] guard_cnt;
    logic [SEL_W-1:0] pending_sel;
    logic             accept;
    logic             same_sel;

    assign req_ready = (state == IDLE);
    assign busy      = !req_ready;
    assign accept    = req_valid && req_ready;
    assign same_sel  = cur_valid && (req_sel == cur_sel);

    // Switch sequencer. Reselecting the already active project is a no-op;
    // anything else tears the current project down first. cur_sel is cleared
    // together with cur_valid so it reads 0 whenever no project is active.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state       <= IDLE;
            guard_cnt   <= '0;
            pending_sel <= '0;
            active_o    <= '0;
            cur_valid   <= 1'b0;
            cur_sel     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept && !same_sel) begin
                        state       <= OFF;
                        active_o    <= '0;
                        cur_valid   <= 1'b0;
                        cur_sel     <= '0;
                        guard_cnt   <= GUARD_LOAD;
                        pending_sel <= req_sel;
                    end
                end
                OFF: begin
                    if (guard_cnt == '0) begin
                        if (pending_sel < SEL_LIMIT) begin
                            state <= ON;
                        end else begin
                            state   <= IDLE;
                            cur_sel <= '0;
                        end
                    end else begin
                        guard_cnt <= guard_cnt - CNT_W'(1);
                    end
                end
                ON: begin
                    active_o  <= ONE_HOT_0 << pending_sel;
                    cur_sel   <= pending_sel;
                    cur_valid <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef SWITCH_CNT_EN
    // Counts completed activations only; deselects and no-ops never reach ON.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            switch_cnt <= '0;
        end else if ((state == ON) && (switch_cnt != 16'hFFFF)) begin
            switch_cnt <= switch_cnt + 16'd1;
        end
    end
`else
    // Activation counter not built in this configuration.
`endif

    // Pads follow the active project only while cur_valid is set, which
    // guarantees hi-Z for the whole guard interval.
    proj_pad_mux #(
        .N_PROJ (N_PROJ),
        .SEL_W  (SEL_W),
        .IO_W   (IO_W)
    ) u_pad_mux (
        .clk         (wb_clk_i),
        .rst         (wb_rst_i),
        .out_en      (cur_valid),
        .sel         (cur_sel),
        .proj_io_out (proj_io_out),
        .proj_io_oeb (proj_io_oeb),
        .io_out      (io_out),
        .io_oeb      (io_oeb)
    );

endmodule
